// File: rtl/shift_tx_pkg.sv
// -----------------------------------------------------------------------------
// shift_tx_pkg
// Shared types and constants for the shift_tx_ctrl serializer.
//   state_t    : controller state encoding. ST_PARITY exists only when
//                SHIFT_TX_PARITY_EN is defined.
//   GAP_W      : width of the inter-frame gap counter (IDLE_GAP 0..15).
//   DIR_LEFT / DIR_RIGHT : legal SHIFT_DIRECTION values.
//   cnt_width(): bit-counter width for a given word width ($clog2(WIDTH)).
// Optional build macro: SHIFT_TX_PARITY_EN (adds the trailing parity state).
// -----------------------------------------------------------------------------
package shift_tx_pkg;

  localparam int    GAP_W     = 4;
  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd3
  } state_t;
`endif

  // Counter must index bits 0..width-1; a 1-bit word would still need 1 bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_tx_ctrl_if
// Word-in / bit-out bundle of the serializer.
//   in_valid, in_data : producer offers a parallel word
//   in_ready          : controller takes the word on this clock edge
//   ser_out           : serial bit
//   ser_valid         : ser_out carries a frame bit this cycle
//   ser_first/ser_last: frame boundary strobes
// Modports:
//   master : the environment (word producer + bit consumer)
//   slave  : the serializer controller
// -----------------------------------------------------------------------------
interface shift_tx_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_first,
    input  ser_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ser_out,
    output ser_valid,
    output ser_first,
    output ser_last
  );

endinterface

// File: rtl/shift_tx_sreg.sv
// -----------------------------------------------------------------------------
// shift_tx_sreg
// WIDTH-bit parallel-load shift register with zero fill.
// Ports:
//   clock      : rising-edge clock
//   aclr_n     : asynchronous active-low clear
//   i_clear    : synchronous clear (highest priority)
//   i_load     : parallel load of i_data (beats i_shift)
//   i_shift    : shift one place toward the output end
//   i_data     : parallel load word
//   o_shiftout : bit currently at the output end
// SHIFT_DIRECTION "LEFT" presents the MSB and shifts toward it;
// "RIGHT" presents the LSB and shifts toward it.
// -----------------------------------------------------------------------------
module shift_tx_sreg
  import shift_tx_pkg::*;
#(
  parameter int    WIDTH           = 8,
  parameter string SHIFT_DIRECTION = "LEFT"
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_shiftout
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (SHIFT_DIRECTION == DIR_RIGHT) begin : g_right
      assign w_shifted  = {1'b0, r_sreg[WIDTH-1:1]};
      assign o_shiftout = r_sreg[0];
    end else begin : g_left
      assign w_shifted  = {r_sreg[WIDTH-2:0], 1'b0};
      assign o_shiftout = r_sreg[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_sreg <= '0;
    end else if (i_clear) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
    end else if (i_shift) begin
      r_sreg <= w_shifted;
    end
  end

endmodule

// File: rtl/shift_tx_ctrl.sv
// -----------------------------------------------------------------------------
// shift_tx_ctrl
// Serializer controller: accepts parallel words over valid/ready and emits
// them one bit per enabled clock, with first/last frame strobes, an optional
// trailing even-parity bit and an optional forced idle gap between frames.
// Ports:
//   clock  : rising-edge clock
//   aclr_n : asynchronous active-low reset
//   enable : clock enable; when low every register holds
//   sclr   : synchronous abort (only acts while enable=1)
//   bus    : shift_tx_ctrl_if.slave (in_valid/in_ready/in_data, ser_*)
//   busy   : controller is not idle
// Parameters: WIDTH (>=2), SHIFT_DIRECTION ("LEFT"/"RIGHT"), IDLE_GAP (0..15)
// Optional build macro: SHIFT_TX_PARITY_EN
//   defined   -> PARITY state appended after the data bits; ser_last on it
//   undefined -> no parity latch; ser_last on data bit WIDTH-1
// -----------------------------------------------------------------------------
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int    WIDTH           = 8,
  parameter string SHIFT_DIRECTION = "LEFT",
  parameter int    IDLE_GAP        = 0
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             enable,
  input  logic             sclr,
  shift_tx_ctrl_if.slave   bus,
  output logic             busy
);

  localparam int                 CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);
  localparam bit                 HAS_GAP  = (IDLE_GAP > 0);
  // GAP counts down to zero, so it is loaded with one less than the length.
  localparam logic [GAP_W-1:0]   GAP_LOAD = HAS_GAP ? GAP_W'(IDLE_GAP - 1) : '0;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_next;

  logic w_advance;
  logic w_abort;
  logic w_at_last_data;
  logic w_frame_end;
  logic w_in_frame;
  logic w_in_ready;
  logic w_accept;
  logic w_sreg_clear;
  logic w_sreg_load;
  logic w_sreg_shift;
  logic w_shiftout;

  assign w_advance      = enable & ~sclr;
  assign w_abort        = enable & sclr;
  assign w_at_last_data = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);

`ifdef SHIFT_TX_PARITY_EN
  logic r_parity;

  assign w_frame_end = (r_state == ST_PARITY);
  assign w_in_frame  = (r_state == ST_SHIFT) || (r_state == ST_PARITY);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^bus.in_data;
    end
  end

  assign bus.ser_out = (r_state == ST_PARITY) ? r_parity : w_shiftout;
`else
  assign w_frame_end = w_at_last_data;
  assign w_in_frame  = (r_state == ST_SHIFT);
  assign bus.ser_out = w_shiftout;
`endif

  // A new word may only overlap the final frame bit when no gap is forced,
  // which gives bubble-free back-to-back frames. Depends on state, enable and
  // sclr only, never on in_valid.
  assign w_in_ready   = w_advance & ((r_state == ST_IDLE) | (w_frame_end & ~HAS_GAP));
  assign w_accept     = bus.in_valid & w_in_ready;
  assign bus.in_ready = w_in_ready;

  // Strobes are gated by enable so a frozen cycle never looks like a bit.
  assign bus.ser_valid = enable & w_in_frame;
  assign bus.ser_first = enable & (r_state == ST_SHIFT) & (r_cnt == '0);
  assign bus.ser_last  = enable & w_frame_end;
  assign busy          = (r_state != ST_IDLE);

  shift_tx_sreg #(
    .WIDTH           (WIDTH),
    .SHIFT_DIRECTION (SHIFT_DIRECTION)
  ) u_sreg (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .i_clear    (w_sreg_clear),
    .i_load     (w_sreg_load),
    .i_shift    (w_sreg_shift),
    .i_data     (bus.in_data),
    .o_shiftout (w_shiftout)
  );

  // Next-state logic. Later assignments in the enabled branch override earlier
  // ones: frame end beats the per-state defaults, and an accept beats both.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap;
    w_sreg_clear = 1'b0;
    w_sreg_load  = 1'b0;
    w_sreg_shift = 1'b0;

    if (w_abort) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_gap_next   = '0;
      w_sreg_clear = 1'b1;
    end else if (enable) begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_SHIFT: begin
          w_sreg_shift = 1'b1;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
`ifdef SHIFT_TX_PARITY_EN
        ST_PARITY: begin
        end
`endif
        ST_GAP: begin
          if (r_gap == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_gap_next = r_gap - GAP_ONE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase

`ifdef SHIFT_TX_PARITY_EN
      if (w_at_last_data) begin
        w_state_next = ST_PARITY;
        w_cnt_next   = '0;
      end
`endif

      if (w_frame_end) begin
        w_cnt_next = '0;
        if (HAS_GAP) begin
          w_state_next = ST_GAP;
          w_gap_next   = GAP_LOAD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      if (w_accept) begin
        w_state_next = ST_SHIFT;
        w_cnt_next   = '0;
        w_sreg_load  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_gap   <= w_gap_next;
    end
  end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
`timescale 1ns/1ps
module tb_shift_tx_ctrl;

  localparam int W = 8;
`ifdef SHIFT_TX_PARITY_EN
  localparam int  FB  = W + 1;
  localparam bit  PAR = 1'b1;
`else
  localparam int  FB  = W;
  localparam bit  PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic clock;
  logic aclr_n;
  logic en_a, sclr_a, busy_a;
  logic en_b, sclr_b, busy_b;

  exp_t qa[$];
  exp_t qb[$];

  int n_vec = 0;
  int n_err = 0;
  int run_a = 0;
  int gap_run_b = 0;
  int last_gap_b = 0;

  shift_tx_ctrl_if #(.WIDTH(W)) bus_a ();
  shift_tx_ctrl_if #(.WIDTH(W)) bus_b ();

  shift_tx_ctrl #(.WIDTH(W), .SHIFT_DIRECTION("LEFT"), .IDLE_GAP(0)) dut_a (
    .clock  (clock),
    .aclr_n (aclr_n),
    .enable (en_a),
    .sclr   (sclr_a),
    .bus    (bus_a.slave),
    .busy   (busy_a)
  );

  shift_tx_ctrl #(.WIDTH(W), .SHIFT_DIRECTION("RIGHT"), .IDLE_GAP(3)) dut_b (
    .clock  (clock),
    .aclr_n (aclr_n),
    .enable (en_b),
    .sclr   (sclr_b),
    .bus    (bus_b.slave),
    .busy   (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Expected frame: LEFT (dut_a) sends MSB first, RIGHT (dut_b) LSB first.
  function automatic void push_frame(input bit to_b, input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b = to_b ? w[i] : w[W-1-i];
      e.f = (i == 0);
      e.l = !PAR && (i == W - 1);
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
    if (PAR) begin
      e.b = ^w;
      e.f = 1'b0;
      e.l = 1'b1;
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endfunction

  // Leaves in_valid high so a following call can stream back-to-back.
  task automatic send_a(input logic [W-1:0] w);
    bit got = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = w;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (bus_a.in_ready === 1'b1) got = 1'b1;
    end
    check($sformatf("a_accept_%0h", w), got, 1);
    if (got) push_frame(1'b0, w);
    @(posedge clock); #1;
  endtask

  task automatic send_b(input logic [W-1:0] w);
    bit got = 1'b0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = w;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (bus_b.in_ready === 1'b1) got = 1'b1;
    end
    check($sformatf("b_accept_%0h", w), got, 1);
    if (got) push_frame(1'b1, w);
    @(posedge clock); #1;
  endtask

  // Monitor for dut_a: scoreboard pops plus contiguous-valid run length.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_a.ser_valid === 1'b1) begin
        run_a++;
        if (qa.size() == 0) begin
          check("a_unexpected_bit", bus_a.ser_valid, 0);
        end else begin
          e = qa.pop_front();
          check("a_ser_out",   bus_a.ser_out,   e.b);
          check("a_ser_first", bus_a.ser_first, e.f);
          check("a_ser_last",  bus_a.ser_last,  e.l);
          $display("a bit: out=%0b first=%0b last=%0b", bus_a.ser_out, bus_a.ser_first, bus_a.ser_last);
        end
      end else begin
        run_a = 0;
        if (bus_a.ser_first !== 1'b0 || bus_a.ser_last !== 1'b0)
          check("a_strobe_without_valid", {bus_a.ser_first, bus_a.ser_last}, 0);
      end
    end
  end

  // Monitor for dut_b: scoreboard pops plus length of the last idle gap.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_b.ser_valid === 1'b1) begin
        if (qb.size() == 0) begin
          check("b_unexpected_bit", bus_b.ser_valid, 0);
        end else begin
          e = qb.pop_front();
          check("b_ser_out",   bus_b.ser_out,   e.b);
          check("b_ser_first", bus_b.ser_first, e.f);
          check("b_ser_last",  bus_b.ser_last,  e.l);
          $display("b bit: out=%0b first=%0b last=%0b", bus_b.ser_out, bus_b.ser_first, bus_b.ser_last);
        end
      end else if (bus_b.ser_first !== 1'b0 || bus_b.ser_last !== 1'b0) begin
        check("b_strobe_without_valid", {bus_b.ser_first, bus_b.ser_last}, 0);
      end
      if (busy_b === 1'b1 && bus_b.ser_valid === 1'b0) begin
        gap_run_b++;
      end else begin
        if (gap_run_b != 0) last_gap_b = gap_run_b;
        gap_run_b = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_a(input string tag);
    repeat (FB + 2) @(posedge clock);
    @(negedge clock);
    check({tag, "_busy"},  busy_a, 0);
    check({tag, "_ready"}, bus_a.in_ready, 1);
    check({tag, "_valid"}, bus_a.ser_valid, 0);
  endtask

  initial begin
    aclr_n = 1'b0;
    en_a = 1'b1; sclr_a = 1'b0;
    en_b = 1'b1; sclr_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;

    // Reset state
    #12;
    check("rst_ser_out",   bus_a.ser_out,   0);
    check("rst_ser_valid", bus_a.ser_valid, 0);
    check("rst_ser_first", bus_a.ser_first, 0);
    check("rst_ser_last",  bus_a.ser_last,  0);
    check("rst_busy_a",    busy_a,          0);
    check("rst_busy_b",    busy_b,          0);
    @(posedge clock); #1;
    aclr_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst_a", bus_a.in_ready, 1);
    check("ready_after_rst_b", bus_b.in_ready, 1);
    en_a = 1'b0;
    #1;
    check("ready_follows_enable", bus_a.in_ready, 0);
    en_a = 1'b1;
    @(posedge clock); #1;

    // Basic frames
    send_a(8'h5D);
    bus_a.in_valid = 1'b0;
    idle_a("basic_5d");
    @(posedge clock); #1;
    send_a(8'h3C);
    bus_a.in_valid = 1'b0;
    idle_a("basic_3c");
    @(posedge clock); #1;

    // Back-to-back with in_valid held
    send_a(8'hA5);
    send_a(8'h3C);
    bus_a.in_valid = 1'b0;
    repeat (FB) @(posedge clock);
    #1;
    check("b2b_contiguous_bits", run_a, 2 * FB);
    idle_a("b2b");
    @(posedge clock); #1;

    // Gap and RIGHT direction
    send_b(8'h01);
    send_b(8'h80);
    bus_b.in_valid = 1'b0;
    repeat (FB + 5) @(posedge clock);
    @(negedge clock);
    check("gap_len", last_gap_b, 3);
    check("gap_busy_end", busy_b, 0);
    check("gap_ready_end", bus_b.in_ready, 1);
    @(posedge clock); #1;

    // Freeze for 3 cycles after bit 3
    send_a(8'h5D);
    bus_a.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("freeze_valid", bus_a.ser_valid, 0);
      check("freeze_busy",  busy_a, 1);
      @(posedge clock); #1;
    end
    en_a = 1'b1;
    idle_a("freeze");
    @(posedge clock); #1;

    // sclr and in_valid together in IDLE: word must be refused
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    sclr_a = 1'b1;
    @(negedge clock);
    check("sclr_blocks_ready", bus_a.in_ready, 0);
    @(posedge clock); #1;
    sclr_a = 1'b0;
    bus_a.in_valid = 1'b0;
    @(negedge clock);
    check("sclr_no_accept_busy", busy_a, 0);
    @(posedge clock); #1;

    // Abort on bit 4
    send_a(8'h5D);
    bus_a.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    sclr_a = 1'b1;
    @(negedge clock);
    check("abort_ready_low", bus_a.in_ready, 0);
    @(posedge clock); #1;
    sclr_a = 1'b0;
    qa.delete();
    @(negedge clock);
    check("abort_valid", bus_a.ser_valid, 0);
    check("abort_ready", bus_a.in_ready, 1);
    check("abort_busy",  busy_a, 0);
    check("abort_ser_out", bus_a.ser_out, 0);
    idle_a("abort");
    @(posedge clock); #1;

    // Asynchronous reset mid-frame (bit 2 of 8'h5D is 1)
    send_a(8'h5D);
    bus_a.in_valid = 1'b0;
    @(posedge clock); #1;
    #1;
    aclr_n = 1'b0;
    #1;
    check("aclr_ser_out",   bus_a.ser_out,   0);
    check("aclr_ser_valid", bus_a.ser_valid, 0);
    check("aclr_ser_first", bus_a.ser_first, 0);
    check("aclr_ser_last",  bus_a.ser_last,  0);
    check("aclr_busy",      busy_a,          0);
    qa.delete();
    @(posedge clock); #1;
    aclr_n = 1'b1;
    @(negedge clock);
    check("aclr_release_ready", bus_a.in_ready, 1);
    @(posedge clock); #1;

    // Recovery frame after reset
    send_a(8'hC3);
    bus_a.in_valid = 1'b0;
    idle_a("recover");

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
